// File: rtl/score_keeper.sv
// Air-hockey match controller: turns goal-sensor levels into per-player scores,
// holds the puck at centre between points, and freezes play once a match is won.
module score_keeper #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 100000000,
  parameter int TIMER_W     = 27
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start_i,
  input  logic       goal1_i,
  input  logic       goal2_i,
  output logic [2:0] score1_o,
  output logic [2:0] score2_o,
  output logic       puck_reset_o,
  output logic       serve_dir_o,
  output logic       game_over_o,
  output logic [1:0] winner_o
);

  // state | meaning
  // IDLE  | powered up, waiting for first start edge; puck held
  // PLAY  | puck live, goal edges score
  // HOLD  | post-goal puck hold, counts HOLD_CYCLES clocks
  // OVER  | match won, scores frozen until start edge
  typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;

  localparam logic [2:0]         WIN_Q     = 3'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);

  state_t             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [2:0]         score1_q, score2_q;
  logic               puck_reset_q, serve_dir_q, game_over_q;
  logic [1:0]         winner_q;
  logic               prev_start_q, prev_g1_q, prev_g2_q;

  logic       start_rise, g1_rise, g2_rise;
  logic [2:0] score1_d, score2_d;

  assign start_rise = start_i & ~prev_start_q;
  assign g1_rise    = goal1_i & ~prev_g1_q;
  assign g2_rise    = goal2_i & ~prev_g2_q;
  assign score1_d   = score1_q + 3'd1;
  assign score2_d   = score2_q + 3'd1;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      puck_reset_q <= 1'b1;
      serve_dir_q  <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
      // Prev regs start high so levels already asserted at release never fire.
      prev_start_q <= 1'b1;
      prev_g1_q    <= 1'b1;
      prev_g2_q    <= 1'b1;
    end else begin
      prev_start_q <= start_i;
      prev_g1_q    <= goal1_i;
      prev_g2_q    <= goal2_i;
      case (state_q)
        IDLE, OVER: begin
          if (start_rise) begin
            score1_q     <= '0;
            score2_q     <= '0;
            winner_q     <= 2'b00;
            game_over_q  <= 1'b0;
            puck_reset_q <= 1'b0;
            state_q      <= PLAY;
          end
        end
        PLAY: begin
          if (g1_rise && g2_rise) begin
            timer_q      <= HOLD_LOAD;
            puck_reset_q <= 1'b1;
            state_q      <= HOLD;
          end else if (g1_rise) begin
            score1_q     <= score1_d;
            puck_reset_q <= 1'b1;
            if (score1_d == WIN_Q) begin
              winner_q    <= 2'b01;
              game_over_q <= 1'b1;
              state_q     <= OVER;
            end else begin
              timer_q     <= HOLD_LOAD;
              serve_dir_q <= 1'b0;
              state_q     <= HOLD;
            end
          end else if (g2_rise) begin
            score2_q     <= score2_d;
            puck_reset_q <= 1'b1;
            if (score2_d == WIN_Q) begin
              winner_q    <= 2'b10;
              game_over_q <= 1'b1;
              state_q     <= OVER;
            end else begin
              timer_q     <= HOLD_LOAD;
              serve_dir_q <= 1'b1;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (timer_q == '0) begin
            puck_reset_q <= 1'b0;
            state_q      <= PLAY;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign score1_o     = score1_q;
  assign score2_o     = score2_q;
  assign puck_reset_o = puck_reset_q;
  assign serve_dir_o  = serve_dir_q;
  assign game_over_o  = game_over_q;
  assign winner_o     = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with a short hold (4 clocks) and a 3-point match.
module tb_score_keeper;

  logic       clock = 1'b0;
  logic       rst, start, goal1, goal2;
  logic [2:0] score1, score2;
  logic       puck_reset, serve_dir, game_over;
  logic [1:0] winner;
  int         n_chk  = 0;
  int         n_pass = 0;

  score_keeper #(.WIN_SCORE(3), .HOLD_CYCLES(4), .TIMER_W(3)) dut (
    .clock       (clock),
    .rst         (rst),
    .start_i     (start),
    .goal1_i     (goal1),
    .goal2_i     (goal2),
    .score1_o    (score1),
    .score2_o    (score2),
    .puck_reset_o(puck_reset),
    .serve_dir_o (serve_dir),
    .game_over_o (game_over),
    .winner_o    (winner)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int s1, input int s2, input int pr,
                         input int sd, input int go, input int w);
    chk({tag, ".score1"}, 32'(score1), 32'(s1));
    chk({tag, ".score2"}, 32'(score2), 32'(s2));
    chk({tag, ".puck"}, 32'(puck_reset), 32'(pr));
    chk({tag, ".serve"}, 32'(serve_dir), 32'(sd));
    chk({tag, ".over"}, 32'(game_over), 32'(go));
    chk({tag, ".winner"}, 32'(winner), 32'(w));
  endtask

  initial begin
    // 1: reset with goal1 held high through release, then start
    rst = 1'b1; start = 1'b0; goal1 = 1'b1; goal2 = 1'b0;
    tick(); tick();
    chk_all("rst", 0, 0, 1, 0, 0, 0);
    rst = 1'b0;
    tick(); tick();
    chk_all("idle", 0, 0, 1, 0, 0, 0);
    goal1 = 1'b0;
    start = 1'b1;
    tick();
    chk_all("start", 0, 0, 0, 0, 0, 0);
    start = 1'b0;
    tick();

    // 2+3: goal1 point, goal2 pulse inside the hold is ignored
    goal1 = 1'b1;
    tick();
    chk_all("g1pt", 1, 0, 1, 0, 0, 0);
    goal1 = 1'b0; goal2 = 1'b1;
    tick();
    chk("hold1.puck", 32'(puck_reset), 1);
    goal2 = 1'b0;
    tick();
    chk("hold2.puck", 32'(puck_reset), 1);
    tick();
    chk("hold3.puck", 32'(puck_reset), 1);
    tick();
    chk_all("hold_end", 1, 0, 0, 0, 0, 0);

    // 3: goal2 held high for 10 clocks scores once
    goal2 = 1'b1;
    tick();
    chk_all("g2pt", 1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    chk_all("g2held", 1, 1, 0, 1, 0, 0);
    goal2 = 1'b0;
    tick();

    // 4: simultaneous goals -> re-serve, no score change
    goal1 = 1'b1; goal2 = 1'b1;
    tick();
    chk_all("both", 1, 1, 1, 1, 0, 0);
    goal1 = 1'b0; goal2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("both_hold.puck", 32'(puck_reset), 1);
    end
    tick();
    chk_all("both_end", 1, 1, 0, 1, 0, 0);

    // 5: player 2 reaches 3 -> OVER without hold
    goal2 = 1'b1;
    tick();
    chk_all("g2pt2", 1, 2, 1, 1, 0, 0);
    goal2 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("g2pt2_end.puck", 32'(puck_reset), 0);
    goal2 = 1'b1;
    tick();
    chk_all("win", 1, 3, 1, 1, 1, 2);
    goal2 = 1'b0;
    tick();
    goal1 = 1'b1;
    tick();
    goal1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_all("frozen", 1, 3, 1, 1, 1, 2);
    start = 1'b1;
    tick();
    chk_all("restart", 0, 0, 0, 1, 0, 0);
    start = 1'b0;
    tick();

    // 6: reset on the 2nd clock of HOLD with score1=2
    goal1 = 1'b1;
    tick();
    chk("s6a.score1", 32'(score1), 1);
    goal1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    goal1 = 1'b1;
    tick();
    chk_all("s6b", 2, 0, 1, 0, 0, 0);
    goal1 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk_all("midhold_rst", 0, 0, 1, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_all("post_rst_idle", 0, 0, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
